// File: rtl/crc_byte_serializer.sv
// crc_byte_serializer: buffers parallel bytes in a small FIFO and shifts each
// one LSB-first to the serial CRC stage, then waits for the stage's complete
// CRC readout (or a timeout) before the next frame may start.
module crc_byte_serializer #(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned CRC_WIDTH  = 8,
   parameter int unsigned FIFO_DEPTH = 4,
   parameter int unsigned TIMEOUT    = 16
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic [DATA_WIDTH-1:0] IN_DATA,
   input  logic                  IN_VALID,
   output logic                  IN_READY,
   output logic                  DATA,
   output logic                  ACTIVE,
   input  logic                  CRC_VALID,
   output logic                  BUSY,
   output logic                  FRAME_DONE,
   output logic                  TIMEOUT_ERR
);

   localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
   localparam int unsigned BW = $clog2(DATA_WIDTH + 1);
   localparam int unsigned WW = $clog2(TIMEOUT + 1);
   localparam int unsigned RW = $clog2(CRC_WIDTH + 1);

   localparam logic [CW-1:0] CNT_FULL  = CW'(FIFO_DEPTH);
   localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_WIDTH);
   localparam logic [WW-1:0] WAIT_LAST = WW'(TIMEOUT);
   localparam logic [RW-1:0] CRC_LAST  = RW'(CRC_WIDTH);

   typedef enum logic [2:0] {
      IDLE,
      SHIFT,
      WAIT_CRC,
      DRAIN,
      GAP
   } state_t;

   state_t state, state_next;

   // FIFO storage and bookkeeping
   logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
   logic [AW-1:0]         wr_ptr, rd_ptr;
   logic [CW-1:0]         count, count_next;
   logic                  push, pop, in_ready_next;
   logic [DATA_WIDTH-1:0] head;

   // Frame datapath
   logic [DATA_WIDTH-1:0] shreg, shreg_next;
   logic [BW-1:0]         bit_cnt, bit_cnt_next;
   logic [WW-1:0]         wait_cnt, wait_cnt_next;
   logic [RW-1:0]         crc_cnt, crc_cnt_next;
   logic                  data_next, active_next, done_next, terr_next;

   // FIFO handshake, occupancy update and registered-ready prediction
   always_comb begin
      head  = mem[rd_ptr];
      push  = IN_VALID & IN_READY;
      pop   = (state == IDLE) && (count != '0);
      count_next = count;
      if (push && !pop) begin
         count_next = count + 1'b1;
      end else if (!push && pop) begin
         count_next = count - 1'b1;
      end
      // Ready stays high when full if the coming edge is certain to pop, so a
      // push and pop on the same edge keeps a full FIFO full without loss.
      in_ready_next = (count_next != CNT_FULL) ||
                      ((state_next == IDLE) && (count_next != '0));
   end

   // FIFO pointers, occupancy count and registered ready
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         IN_READY <= 1'b0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         count    <= count_next;
         IN_READY <= in_ready_next;
      end
   end

   // FIFO storage write (no reset needed on data)
   always_ff @(posedge CLK) begin
      if (push) mem[wr_ptr] <= IN_DATA;
   end

   // Next-state and next-output decode for the frame FSM
   always_comb begin
      state_next    = state;
      shreg_next    = shreg;
      bit_cnt_next  = bit_cnt;
      wait_cnt_next = wait_cnt;
      crc_cnt_next  = crc_cnt;
      data_next     = 1'b0;
      active_next   = 1'b0;
      done_next     = 1'b0;
      terr_next     = 1'b0;
      unique case (state)
         IDLE: begin
            if (count != '0) begin
               shreg_next   = head >> 1;
               data_next    = head[0];
               active_next  = 1'b1;
               bit_cnt_next = BW'(1);
               state_next   = SHIFT;
            end
         end
         SHIFT: begin
            if (bit_cnt == BIT_LAST) begin
               wait_cnt_next = '0;
               state_next    = WAIT_CRC;
            end else begin
               data_next    = shreg[0];
               active_next  = 1'b1;
               shreg_next   = shreg >> 1;
               bit_cnt_next = bit_cnt + 1'b1;
            end
         end
         WAIT_CRC: begin
            if (CRC_VALID) begin
               if (CRC_LAST == RW'(1)) begin
                  done_next  = 1'b1;
                  state_next = GAP;
               end else begin
                  crc_cnt_next = RW'(1);
                  state_next   = DRAIN;
               end
            end else if (wait_cnt + 1'b1 == WAIT_LAST) begin
               terr_next  = 1'b1;
               state_next = GAP;
            end else begin
               wait_cnt_next = wait_cnt + 1'b1;
            end
         end
         DRAIN: begin
            if (!CRC_VALID) begin
               terr_next  = 1'b1;
               state_next = GAP;
            end else if (crc_cnt + 1'b1 == CRC_LAST) begin
               done_next  = 1'b1;
               state_next = GAP;
            end else begin
               crc_cnt_next = crc_cnt + 1'b1;
            end
         end
         GAP: begin
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // FSM state register
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Registered datapath counters and outputs
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         shreg       <= '0;
         bit_cnt     <= '0;
         wait_cnt    <= '0;
         crc_cnt     <= '0;
         DATA        <= 1'b0;
         ACTIVE      <= 1'b0;
         BUSY        <= 1'b0;
         FRAME_DONE  <= 1'b0;
         TIMEOUT_ERR <= 1'b0;
      end else begin
         shreg       <= shreg_next;
         bit_cnt     <= bit_cnt_next;
         wait_cnt    <= wait_cnt_next;
         crc_cnt     <= crc_cnt_next;
         DATA        <= data_next;
         ACTIVE      <= active_next;
         BUSY        <= (state_next != IDLE);
         FRAME_DONE  <= done_next;
         TIMEOUT_ERR <= terr_next;
      end
   end

endmodule

// File: tb/tb_crc_byte_serializer.sv
// tb_crc_byte_serializer: directed and randomized checks of the byte
// serializer against a frame-level reference model and a CRC-stage model.
module tb_crc_byte_serializer;

   localparam int unsigned DW = 8;
   localparam int unsigned CW = 8;
   localparam int unsigned FD = 4;
   localparam int unsigned TO = 16;

   logic          CLK = 1'b0;
   logic          RST;
   logic [DW-1:0] IN_DATA;
   logic          IN_VALID;
   logic          IN_READY;
   logic          DATA;
   logic          ACTIVE;
   logic          CRC_VALID = 1'b0;
   logic          BUSY;
   logic          FRAME_DONE;
   logic          TIMEOUT_ERR;

   crc_byte_serializer #(
      .DATA_WIDTH (DW),
      .CRC_WIDTH  (CW),
      .FIFO_DEPTH (FD),
      .TIMEOUT    (TO)
   ) dut (
      .CLK         (CLK),
      .RST         (RST),
      .IN_DATA     (IN_DATA),
      .IN_VALID    (IN_VALID),
      .IN_READY    (IN_READY),
      .DATA        (DATA),
      .ACTIVE      (ACTIVE),
      .CRC_VALID   (CRC_VALID),
      .BUSY        (BUSY),
      .FRAME_DONE  (FRAME_DONE),
      .TIMEOUT_ERR (TIMEOUT_ERR)
   );

   always #5 CLK = ~CLK;

   int checks = 0;
   int errors = 0;

   // Bytes accepted by the handshake and not yet fully serialized
   logic [7:0] exp_q [$];

   // CRC-stage behaviour for the next frame
   int crc_len   = 8;
   int crc_delay = 2;
   bit rand_mode = 1'b0;

   // Monitor / CRC-stage model state
   int         cyc = 0;
   bit         pend = 1'b0;
   int         dly = 0;
   int         left = 0;
   bit         prev_active = 1'b0;
   int         nbits = 0;
   logic [7:0] cap = '0;
   logic [7:0] lfsr = '0;
   logic [7:0] mhb;
   logic       fb;
   bit         hit;
   bit         exp_valid = 1'b0;
   int         exp_cyc = 0;
   bit         exp_done_kind = 1'b0;
   int         last_evt_cyc = 0;
   bit         have_evt = 1'b0;
   int         done_cnt = 0;
   int         to_cnt = 0;
   int unsigned r;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   // CRC-8 (x^8+x^2+x+1, init 0) of the byte sent LSB-first, by long division
   function automatic logic [7:0] crc_ref(input logic [7:0] b);
      logic [15:0] v;
      v = '0;
      for (int i = 0; i < 8; i++) v[15-i] = b[i];
      for (int i = 15; i >= 8; i--) begin
         if (v[i]) v = v ^ (16'h0107 << (i - 8));
      end
      return v[7:0];
   endfunction

   // Frame monitor plus a CRC-stage model that answers each finished frame
   always @(negedge CLK) begin
      cyc++;
      if (!RST) begin
         prev_active = 1'b0;
         nbits       = 0;
         pend        = 1'b0;
         left        = 0;
         exp_valid   = 1'b0;
         CRC_VALID   = 1'b0;
         cap         = '0;
         lfsr        = '0;
      end else begin
         if (CRC_VALID) begin
            left--;
            if (left <= 0) CRC_VALID = 1'b0;
         end
         if (FRAME_DONE || TIMEOUT_ERR || (exp_valid && cyc == exp_cyc)) begin
            hit = exp_valid && (cyc == exp_cyc);
            chk("frame_done", FRAME_DONE, hit && exp_done_kind);
            chk("timeout_err", TIMEOUT_ERR, hit && !exp_done_kind);
            if (FRAME_DONE) done_cnt++;
            if (TIMEOUT_ERR) to_cnt++;
            if (hit) exp_valid = 1'b0;
            last_evt_cyc = cyc;
            have_evt     = 1'b1;
         end
         if (ACTIVE && !prev_active) begin
            chk("no_overlap", exp_valid, 0);
            if (have_evt) chk("gap_after_evt", (cyc - last_evt_cyc) >= 2, 1);
            nbits = 0;
            cap   = '0;
            lfsr  = '0;
         end
         if (ACTIVE) begin
            if (exp_q.size() > 0 && nbits < 8) begin
               mhb = exp_q[0];
               chk("data_bit", DATA, mhb[nbits]);
            end
            if (nbits < 8) cap[nbits] = DATA;
            fb   = lfsr[7] ^ DATA;
            lfsr = {lfsr[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
            nbits++;
         end else begin
            chk("data_idle", DATA, 0);
         end
         if (!ACTIVE && prev_active) begin
            chk("active_len", nbits, DW);
            chk("rx_queue_nonempty", exp_q.size() != 0, 1);
            if (exp_q.size() > 0) begin
               mhb = exp_q.pop_front();
               chk("rx_byte", cap, mhb);
               chk("crc_golden", lfsr, crc_ref(mhb));
            end
            if (rand_mode) begin
               crc_delay = $urandom_range(0, 6);
               r = $urandom_range(0, 9);
               crc_len = (r < 7) ? 8 : ((r < 9) ? 3 : 0);
            end
            exp_valid = 1'b1;
            if (crc_len == 0) begin
               exp_cyc = cyc + TO;
               exp_done_kind = 1'b0;
            end else if (crc_len < CW) begin
               exp_cyc = cyc + crc_delay + crc_len + 1;
               exp_done_kind = 1'b0;
            end else begin
               exp_cyc = cyc + crc_delay + CW;
               exp_done_kind = 1'b1;
            end
            if (crc_len > 0) begin
               pend = 1'b1;
               dly  = crc_delay;
            end
         end
         if (pend) begin
            if (dly == 0) begin
               pend      = 1'b0;
               CRC_VALID = 1'b1;
               left      = crc_len;
            end else begin
               dly--;
            end
         end
         prev_active = ACTIVE;
      end
   end

   task automatic push(input logic [7:0] b, output int waited, output logic busy_at);
      waited   = 0;
      IN_DATA  = b;
      IN_VALID = 1'b1;
      while (!IN_READY && waited < 300) begin
         @(negedge CLK);
         waited++;
      end
      chk("push_ready", IN_READY, 1);
      if (IN_READY) exp_q.push_back(b);
      busy_at = BUSY;
      @(negedge CLK);
      IN_VALID = 1'b0;
   endtask

   task automatic drain(input int limit);
      int n;
      n = 0;
      while (!(exp_q.size() == 0 && !BUSY && !ACTIVE && !exp_valid && !pend && !CRC_VALID)
             && n < limit) begin
         @(negedge CLK);
         n++;
      end
      chk("drain_done", n < limit, 1);
      @(negedge CLK);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      int         w, wsum, d0, t0;
      logic       b;
      bit         any_active;
      logic [7:0] six [6];
      six[0] = 8'h01; six[1] = 8'h02; six[2] = 8'h04;
      six[3] = 8'h08; six[4] = 8'h10; six[5] = 8'h20;

      RST = 1'b0; IN_VALID = 1'b0; IN_DATA = '0;
      repeat (3) @(negedge CLK);
      chk("rst_active", ACTIVE, 0);
      chk("rst_data", DATA, 0);
      chk("rst_busy", BUSY, 0);
      chk("rst_done", FRAME_DONE, 0);
      chk("rst_terr", TIMEOUT_ERR, 0);
      chk("rst_in_ready", IN_READY, 0);
      RST = 1'b1;
      @(negedge CLK);
      chk("ready_after_rst", IN_READY, 1);
      chk("busy_after_rst", BUSY, 0);

      // Single frame 0xD3 with full CRC readout two cycles after ACTIVE falls
      crc_len = 8; crc_delay = 2;
      d0 = done_cnt;
      push(8'hD3, w, b);
      chk("lat_early", ACTIVE, 0);
      @(negedge CLK);
      chk("lat_first", ACTIVE, 1);
      chk("lat_busy", BUSY, 1);
      drain(200);
      chk("d3_done_count", done_cnt - d0, 1);

      // Reset mid-shift after three bits of 0xA5
      d0 = done_cnt + to_cnt;
      push(8'hA5, w, b);
      repeat (3) @(negedge CLK);
      #2 RST = 1'b0;
      #1;
      chk("mid_rst_active", ACTIVE, 0);
      chk("mid_rst_data", DATA, 0);
      chk("mid_rst_busy", BUSY, 0);
      chk("mid_rst_ready", IN_READY, 0);
      exp_q.delete();
      @(negedge CLK);
      @(negedge CLK);
      RST = 1'b1;
      @(negedge CLK);
      chk("mid_rst_ready_rel", IN_READY, 1);
      chk("mid_rst_busy_rel", BUSY, 0);
      any_active = 1'b0;
      repeat (12) begin
         @(negedge CLK);
         any_active |= ACTIVE;
      end
      chk("mid_rst_fifo_empty", any_active, 0);
      chk("mid_rst_no_pulse", done_cnt + to_cnt - d0, 0);

      // Six back-to-back bytes with CRC_VALID never arriving
      crc_len = 0; crc_delay = 0;
      t0 = to_cnt;
      wsum = 0;
      for (int i = 0; i < 5; i++) begin
         push(six[i], w, b);
         wsum += w;
      end
      chk("five_no_stall", wsum, 0);
      chk("ready_full", IN_READY, 0);
      push(six[5], w, b);
      chk("sixth_stalled", w >= 20, 1);
      chk("full_pop_idle", b, 0);
      chk("ready_after_full_pop", IN_READY, 0);
      drain(800);
      chk("six_timeouts", to_cnt - t0, 6);

      // CRC_VALID drops after 5 of 8 cycles, for two consecutive frames
      crc_len = 5; crc_delay = 1;
      d0 = done_cnt; t0 = to_cnt;
      push(8'h3C, w, b);
      push(8'hC3, w, b);
      drain(300);
      chk("early_drop_terr", to_cnt - t0, 2);
      chk("early_drop_no_done", done_cnt - d0, 0);

      // Golden frames 0x00 and 0xFF with full readout
      crc_len = 8; crc_delay = 0;
      d0 = done_cnt;
      push(8'h00, w, b);
      push(8'hFF, w, b);
      drain(300);
      chk("golden_done", done_cnt - d0, 2);

      // Randomized bytes, input gaps and CRC-stage behaviour
      rand_mode = 1'b1;
      d0 = done_cnt + to_cnt;
      for (int i = 0; i < 24; i++) begin
         repeat ($urandom_range(0, 3)) @(negedge CLK);
         push(8'($urandom), w, b);
      end
      drain(3000);
      rand_mode = 1'b0;
      chk("rand_events", done_cnt + to_cnt - d0, 24);
      chk("queue_empty", exp_q.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
